// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag sequencer for an external 2^W-entry register file.
// Define FIFO_LEVEL_EN to add the registered count and almost_full outputs.
module fifo_ctrl #(
   parameter int W        = 3,
   parameter int AF_LEVEL = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic         rd,
   output logic         wr_en,
   output logic [W-1:0] w_addr,
   output logic [W-1:0] r_addr,
   output logic         empty,
`ifdef FIFO_LEVEL_EN
   output logic [W:0]   count,
   output logic         almost_full,
`endif
   output logic         full
);

   logic [W-1:0] w_addr_q, w_addr_d;
   logic [W-1:0] r_addr_q, r_addr_d;
   logic         empty_q, empty_d;
   logic         full_q, full_d;
   logic         push, pop;
   logic [W-1:0] w_addr_inc, r_addr_inc;

   // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
   assign push       = wr & (~full_q | rd);
   assign pop        = rd & ~empty_q;
   assign w_addr_inc = w_addr_q + W'(1);
   assign r_addr_inc = r_addr_q + W'(1);

   always_comb begin
      w_addr_d = w_addr_q;
      r_addr_d = r_addr_q;
      empty_d  = empty_q;
      full_d   = full_q;
      if (push) w_addr_d = w_addr_inc;
      if (pop)  r_addr_d = r_addr_inc;
      if (push && !pop) begin
         empty_d = 1'b0;
         full_d  = (w_addr_inc == r_addr_q);
      end else if (pop && !push) begin
         full_d  = 1'b0;
         empty_d = (r_addr_inc == w_addr_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_addr_q <= '0;
         r_addr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         w_addr_q <= w_addr_d;
         r_addr_q <= r_addr_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign wr_en  = push;
   assign w_addr = w_addr_q;
   assign r_addr = r_addr_q;
   assign empty  = empty_q;
   assign full   = full_q;

`ifdef FIFO_LEVEL_EN
   localparam logic [W:0] AF_THRESH = (W+1)'(AF_LEVEL);

   logic [W:0] count_q, count_d;
   logic       almost_full_q, almost_full_d;

   // almost_full is derived from the next count so both registers agree every cycle.
   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + (W+1)'(1);
      else if (pop && !push) count_d = count_q - (W+1)'(1);
      almost_full_d = (count_d >= AF_THRESH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         count_q       <= count_d;
         almost_full_q <= almost_full_d;
      end
   end

   assign count       = count_q;
   assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: occupancy model built from push/pop totals.
// Compile with FIFO_LEVEL_EN defined to also check count and almost_full.
module tb_fifo_ctrl;

   localparam int W        = 3;
   localparam int AF_LEVEL = 6;
   localparam int DEPTH    = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr;
   logic         rd;
   logic         wr_en;
   logic [W-1:0] w_addr;
   logic [W-1:0] r_addr;
   logic         empty;
   logic         full;
`ifdef FIFO_LEVEL_EN
   logic [W:0]   count;
   logic         almost_full;
`endif

   fifo_ctrl #(.W(W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr),
      .rd          (rd),
      .wr_en       (wr_en),
      .w_addr      (w_addr),
      .r_addr      (r_addr),
      .empty       (empty),
`ifdef FIFO_LEVEL_EN
      .count       (count),
      .almost_full (almost_full),
`endif
      .full        (full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tag;
      bit wr;
      bit rd;
      bit wr_en;
      int w_addr;
      int r_addr;
      bit empty;
      bit full;
      int count;
      bit almost_full;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   tag    = 0;

   // Reference model: FIFO state is just how many pushes and pops have been accepted.
   int n_push = 0;
   int n_pop  = 0;

   function automatic exp_t expect_now(bit w, bit r, bit in_reset);
      exp_t e;
      int   occ;
      occ           = n_push - n_pop;
      e.tag         = tag;
      e.wr          = w;
      e.rd          = r;
      e.wr_en       = w && (occ < DEPTH || r);
      e.w_addr      = n_push % DEPTH;
      e.r_addr      = n_pop % DEPTH;
      e.empty       = (occ == 0);
      e.full        = (occ == DEPTH);
      e.count       = occ;
      e.almost_full = (occ >= AF_LEVEL);
      if (in_reset) e.wr_en = w;
      return e;
   endfunction

   task automatic drive(input bit w, input bit r);
      exp_t e;
      bit   acc_push, acc_pop;
      @(posedge clk);
      #1;
      rst = 1'b1;
      wr  = w;
      rd  = r;
      e   = expect_now(w, r, 1'b0);
      sb.push_back(e);
      tag++;
      acc_push = w && ((n_push - n_pop) < DEPTH || r);
      acc_pop  = r && ((n_push - n_pop) > 0);
      if (acc_push) n_push++;
      if (acc_pop)  n_pop++;
   endtask

   task automatic async_reset();
      @(posedge clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
      #2;
      rst    = 1'b0;
      n_push = 0;
      n_pop  = 0;
      sb.push_back(expect_now(1'b0, 1'b0, 1'b1));
      tag++;
   endtask

   task automatic chk(input string name, input int tg, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s txn=%0d actual=%0d expected=%0d", name, tg, act, exp_v);
      end
   endtask

   // Monitor: outputs are always presented, so sample one record per falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         $display("txn %0d wr=%b rd=%b wr_en=%b w_addr=%0d r_addr=%0d empty=%b full=%b",
                  e.tag, e.wr, e.rd, wr_en, w_addr, r_addr, empty, full);
         chk("wr_en",  e.tag, int'(wr_en),  int'(e.wr_en));
         chk("w_addr", e.tag, int'(w_addr), e.w_addr);
         chk("r_addr", e.tag, int'(r_addr), e.r_addr);
         chk("empty",  e.tag, int'(empty),  int'(e.empty));
         chk("full",   e.tag, int'(full),   int'(e.full));
`ifdef FIFO_LEVEL_EN
         chk("count",       e.tag, int'(count),       e.count);
         chk("almost_full", e.tag, int'(almost_full), int'(e.almost_full));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog txn=%0d actual=timeout expected=finish", tag);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pw, pr;
      rst = 1'b0;
      wr  = 1'b0;
      rd  = 1'b0;
      sb.push_back(expect_now(1'b0, 1'b0, 1'b1));
      tag++;
      @(negedge clk);

      // Fill to full, then push against full, then push+pop while full.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b1);

      // Simultaneous request while empty.
      async_reset();
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);

      // 3 pushes, 3 pops, an extra pop on empty.
      async_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);

      // Reset mid-operation with 5 entries held.
      async_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
      async_reset();
      drive(1'b1, 1'b0);

      // Random traffic with a bias that drifts between fill-heavy and drain-heavy.
      for (int blk = 0; blk < 8; blk++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 50; i++)
            drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
         if (blk == 4) async_reset();
      end
      drive(1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
